gfa_komut_hakem: RTL
====================

Name: gfa_komut_hakem

Overview:
- Round-robin arbiter that shares one general FIFO interface among ISTEKCI requesters: a downstream command channel (komut) and a returning data channel (veri).
- Each requester owns one command/data channel pair.
- Granted commands are registered and forwarded downstream. The requester index of every issued command is pushed into an in-order tag FIFO, so each returning veri word is steered back to the requester whose command produced it.
- The block sits between core-side masters and the AXI4-Lite/GFA bridge command and data ports.

Parameters:
ISTEKCI, 2, number of requesters (2..8)
VERI_BIT, 32, command/data word width
SIRA_DERINLIK, 4, max outstanding commands awaiting veri (power of 2)

Ports:
ACLK  in  1  clock, rising edge
ARESET  in  1  asynchronous, active-high reset
ist_komut_gecerli  in  ISTEKCI  per-requester command valid
ist_komut  in  ISTEKCI*VERI_BIT  packed commands, requester i at [i*VERI_BIT +: VERI_BIT]
ist_komut_hazir  out  ISTEKCI  per-requester command accept
ist_veri  out  VERI_BIT  returned data, broadcast to all requesters
ist_veri_gecerli  out  ISTEKCI  one-hot data valid to owning requester
ist_veri_hazir  in  ISTEKCI  per-requester data ready
komut_gecerli  out  1  downstream command valid
komut  out  VERI_BIT  downstream command word
komut_hazir  in  1  downstream command ready
veri  in  VERI_BIT  downstream returned data
veri_gecerli  in  1  downstream data valid
veri_hazir  out  1  downstream data ready
bekleyen  out  clog2(SIRA_DERINLIK)+1  outstanding tag count
hata  out  1  sticky: veri_gecerli seen with no outstanding tag

Behaviour:
Handshake rule:
- Every channel transfers on the rising ACLK edge where its gecerli and hazir are both 1.
- Once asserted, gecerli must hold with stable data until the transfer.

Reset (ARESET high, asynchronous):
- State BOSTA, round-robin pointer 0, tag FIFO empty, bekleyen 0, hata 0, komut 0.
- komut_gecerli, veri_hazir, all ist_komut_hazir and all ist_veri_gecerli are 0.
- All combinational outputs are gated by ~ARESET.
- Reset mid-operation discards the held command and all outstanding tags.

Arbitration FSM:
- BOSTA:
  - grant = first i with ist_komut_gecerli[i], scanning from pointer upward with wrap.
  - If any request and bekleyen < SIRA_DERINLIK: ist_komut_hazir[grant]=1 (combinational, one-hot); komut_r <= ist_komut[grant]; tag_r <= grant; -> GONDER.
  - Otherwise all ist_komut_hazir are 0.
- GONDER:
  - komut_gecerli=1 from a register; komut=komut_r.
  - All ist_komut_hazir are 0.
  - On komut_hazir: push tag_r into the tag FIFO; pointer <= (tag_r+1) mod ISTEKCI; -> BOSTA.
  - Otherwise hold.
- Throughput: at most one command per 2 cycles.
- Latency: requester accept to komut_gecerli is 1 cycle.

Return path (combinational):
- head = tag FIFO read entry.
- ist_veri = veri.
- ist_veri_gecerli[head] = veri_gecerli & (bekleyen != 0); all other bits 0.
- veri_hazir = (bekleyen != 0) & ist_veri_hazir[head].
- On a downstream veri handshake, pop the tag FIFO.

Boundary conditions:
- Simultaneous push and pop: bekleyen is unchanged and both pointers advance. Pointers wrap mod SIRA_DERINLIK.
- bekleyen == SIRA_DERINLIK: BOSTA accepts nothing; a pop in the same cycle unblocks the next cycle.
- veri_gecerli while bekleyen == 0: veri_hazir stays 0 and hata sets, clearing only on reset.
- ist_veri_hazir low for the head owner: the return channel stalls; the arbiter may keep issuing while bekleyen < SIRA_DERINLIK.
- A requester dropping gecerli while in BOSTA is not granted that cycle.

Test Plan:
- Reset then single request: ist_komut_gecerli=01, ist_komut[0]=32'hA5A5_0001, komut_hazir=1.
  - Required: ist_komut_hazir=01 in cycle 0; komut=32'hA5A5_0001 with komut_gecerli in cycle 1; bekleyen=1.
  - Then veri=32'h1234 with veri_gecerli: ist_veri_gecerli=01, bekleyen=0.
- Both requesters held continuously, komut_hazir=1, ISTEKCI=2:
  - Required: grants alternate 0,1,0,1 every 2 cycles.
  - Required: four returned words route to requesters 0,1,0,1 in order.
- Downstream backpressure: komut_hazir=0 for 5 cycles.
  - Required: komut_gecerli held, komut stable, no ist_komut_hazir.
  - Release: one push, then state BOSTA.
- Full: issue 4 commands with no veri.
  - Required: bekleyen=4 and ist_komut_hazir stays 0.
  - One veri handshake gives bekleyen=3 and a new grant next cycle.
- Spurious veri_gecerli with bekleyen=0:
  - Required: veri_hazir=0 and hata=1.
  - Pulsing ARESET mid-GONDER clears hata, bekleyen and komut_gecerli immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gfa_komut_hakem_if.sv
// Requester-side and downstream-side handshake bundle for the round-robin command arbiter.
// master is the arbiter's own view; slave is the view of whatever surrounds it.
interface gfa_komut_hakem_if #(
  parameter int ISTEKCI       = 2,
  parameter int VERI_BIT      = 32,
  parameter int SIRA_DERINLIK = 4
);
  localparam int CW = $clog2(SIRA_DERINLIK) + 1;

  // Requester side
  logic [ISTEKCI-1:0]          ist_komut_gecerli;
  logic [ISTEKCI*VERI_BIT-1:0] ist_komut;
  logic [ISTEKCI-1:0]          ist_komut_hazir;
  logic [VERI_BIT-1:0]         ist_veri;
  logic [ISTEKCI-1:0]          ist_veri_gecerli;
  logic [ISTEKCI-1:0]          ist_veri_hazir;

  // Downstream side
  logic                        komut_gecerli;
  logic [VERI_BIT-1:0]         komut;
  logic                        komut_hazir;
  logic [VERI_BIT-1:0]         veri;
  logic                        veri_gecerli;
  logic                        veri_hazir;

  // Status
  logic [CW-1:0]               bekleyen;
  logic                        hata;

  modport master (
    input  ist_komut_gecerli, ist_komut, ist_veri_hazir,
    input  komut_hazir, veri, veri_gecerli,
    output ist_komut_hazir, ist_veri, ist_veri_gecerli,
    output komut_gecerli, komut, veri_hazir,
    output bekleyen, hata
  );

  modport slave (
    output ist_komut_gecerli, ist_komut, ist_veri_hazir,
    output komut_hazir, veri, veri_gecerli,
    input  ist_komut_hazir, ist_veri, ist_veri_gecerli,
    input  komut_gecerli, komut, veri_hazir,
    input  bekleyen, hata
  );
endinterface

// File: rtl/gfa_komut_hakem.sv
// Round-robin arbiter sharing one command/data channel pair among ISTEKCI requesters.
// An in-order tag FIFO remembers who issued each command so returning data is steered back.
module gfa_komut_hakem #(
  parameter int ISTEKCI       = 2,
  parameter int VERI_BIT      = 32,
  parameter int SIRA_DERINLIK = 4
) (
  input  logic                ACLK,
  input  logic                ARESET,
  gfa_komut_hakem_if.master   bus
);
  localparam int IW = (ISTEKCI > 1) ? $clog2(ISTEKCI) : 1;
  localparam int AW = (SIRA_DERINLIK > 1) ? $clog2(SIRA_DERINLIK) : 1;
  localparam int CW = $clog2(SIRA_DERINLIK) + 1;

  typedef enum logic {BOSTA, GONDER} durum_t;

  durum_t              durum_q, durum_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       tag_q, tag_d;
  logic [VERI_BIT-1:0] komut_q, komut_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                hata_q, hata_d;
  logic [AW-1:0]       wr_q, rd_q;
  logic [IW-1:0]       tag_mem_q [SIRA_DERINLIK];

  logic [VERI_BIT-1:0] komut_sec [ISTEKCI];
  logic [ISTEKCI-1:0]  hazir;
  logic [IW-1:0]       grant;
  logic [IW-1:0]       head;
  logic                any_req;
  logic                dolu;
  logic                var_tag;
  logic                veri_hazir_w;
  logic                push;
  logic                pop;

  genvar gi;
  generate
    for (gi = 0; gi < ISTEKCI; gi++) begin : g_ist
      assign komut_sec[gi] = bus.ist_komut[gi*VERI_BIT +: VERI_BIT];
      assign bus.ist_veri_gecerli[gi] = ~ARESET & var_tag & bus.veri_gecerli
                                        & (head == IW'(gi));
    end
  endgenerate

  // Scan from the pointer upward with wrap; the smallest offset with a request wins.
  always_comb begin
    int idx;
    idx     = 0;
    grant   = ptr_q;
    any_req = 1'b0;
    for (int k = ISTEKCI - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % ISTEKCI;
      if (bus.ist_komut_gecerli[idx]) begin
        grant   = IW'(idx);
        any_req = 1'b1;
      end
    end
  end

  assign dolu = (cnt_q >= CW'(SIRA_DERINLIK));

  always_comb begin
    durum_d = durum_q;
    ptr_d   = ptr_q;
    tag_d   = tag_q;
    komut_d = komut_q;
    hazir   = '0;
    push    = 1'b0;
    case (durum_q)
      BOSTA: begin
        if (any_req && !dolu) begin
          hazir[grant] = 1'b1;
          komut_d      = komut_sec[grant];
          tag_d        = grant;
          durum_d      = GONDER;
        end
      end
      GONDER: begin
        if (bus.komut_hazir) begin
          push    = 1'b1;
          ptr_d   = (tag_q == IW'(ISTEKCI - 1)) ? '0 : tag_q + 1'b1;
          durum_d = BOSTA;
        end
      end
      default: durum_d = BOSTA;
    endcase
  end

  assign head         = tag_mem_q[rd_q];
  assign var_tag      = (cnt_q != '0);
  assign veri_hazir_w = ~ARESET & var_tag & bus.ist_veri_hazir[head];
  assign pop          = bus.veri_gecerli & veri_hazir_w;
  assign cnt_d        = cnt_q + CW'(push) - CW'(pop);
  assign hata_d       = hata_q | (bus.veri_gecerli & ~var_tag);

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      durum_q <= BOSTA;
      ptr_q   <= '0;
      tag_q   <= '0;
      komut_q <= '0;
      cnt_q   <= '0;
      hata_q  <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      durum_q <= durum_d;
      ptr_q   <= ptr_d;
      tag_q   <= tag_d;
      komut_q <= komut_d;
      cnt_q   <= cnt_d;
      hata_q  <= hata_d;
      if (push) wr_q <= wr_q + 1'b1;
      if (pop)  rd_q <= rd_q + 1'b1;
    end
  end

  // Tag storage needs no reset: only entries between the pointers are ever read.
  always_ff @(posedge ACLK) begin
    if (push) tag_mem_q[wr_q] <= tag_q;
  end

  assign bus.ist_komut_hazir = hazir & {ISTEKCI{~ARESET}};
  assign bus.ist_veri        = bus.veri & {VERI_BIT{~ARESET}};
  assign bus.komut_gecerli   = ~ARESET & (durum_q == GONDER);
  assign bus.komut           = komut_q;
  assign bus.veri_hazir      = veri_hazir_w;
  assign bus.bekleyen        = cnt_q;
  assign bus.hata            = hata_q;
endmodule
